// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare-match flag and level irq on the core data port.
// Latency: reads are combinational (zero cycles); writes land on the next rising clk edge.
// Backpressure: none; every access completes in the cycle it is presented.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic        hit,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  logic                  en;
  logic                  autoreload;
  logic                  irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] prescnt;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  match;

  logic       wr;
  logic [2:0] reg_sel;
  logic       tick;
  logic       count_eq;

  // Window decode: aligned word offsets 0x00..0x10 only.
  assign reg_sel  = memaddr[4:2];
  assign hit      = (memaddr[31:5] == BASE_ADDR[31:5]) && (reg_sel <= OFF_STATUS)
                    && (memaddr[1:0] == 2'b00);
  assign wr       = memwrite && hit;
  assign tick     = en && (prescnt == prescale);
  assign count_eq = (count == compare);
  assign irq      = match && irq_en;

  // Zero-latency read mux from current register state; no read side effects.
  always_comb begin
    readdata = 32'd0;
    if (hit) begin
      case (reg_sel)
        OFF_CTRL:     readdata = {29'd0, irq_en, autoreload, en};
        OFF_PRESCALE: readdata = 32'(prescale);
        OFF_COUNT:    readdata = count;
        OFF_COMPARE:  readdata = compare;
        OFF_STATUS:   readdata = {31'd0, match};
        default:      readdata = 32'd0;
      endcase
    end
  end

  // Control and compare registers: plain CPU-written state.
  always_ff @(posedge clk) begin
    if (reset) begin
      en         <= 1'b0;
      autoreload <= 1'b0;
      irq_en     <= 1'b0;
      prescale   <= '0;
      compare    <= 32'hFFFF_FFFF;
    end else if (wr) begin
      case (reg_sel)
        OFF_CTRL: begin
          en         <= memwritedata[0];
          autoreload <= memwritedata[1];
          irq_en     <= memwritedata[2];
        end
        OFF_PRESCALE: prescale <= memwritedata[PRESCALE_W-1:0];
        OFF_COMPARE:  compare  <= memwritedata;
        default: ;
      endcase
    end
  end

  // Prescaler: counts up to PRESCALE then wraps; a PRESCALE write restarts the period.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescnt <= '0;
    end else if (wr && (reg_sel == OFF_PRESCALE)) begin
      prescnt <= '0;
    end else if (tick) begin
      prescnt <= '0;
    end else if (en) begin
      prescnt <= prescnt + 1'b1;
    end
  end

  // Counter: a CPU write overrides the tick update; the compare always sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 32'd0;
    end else if (wr && (reg_sel == OFF_COUNT)) begin
      count <= memwritedata;
    end else if (tick) begin
      count <= (count_eq && autoreload) ? 32'd0 : count + 32'd1;
    end
  end

  // Sticky match flag: a new match beats a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else if (tick && count_eq) begin
      match <= 1'b1;
    end else if (wr && (reg_sel == OFF_STATUS) && memwritedata[0]) begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: directed scenarios followed by randomized bus traffic.
// Expected outputs come from a register-level reference model and are queued per cycle.
// A monitor process pops the queue and compares hit/readdata/irq mid-cycle.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic        hit;
  logic [31:0] readdata;
  logic        irq;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .hit(hit), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] rd;
    logic        irq;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // Reference model: the register file as the software sees it.
  bit        m_en, m_ar, m_ie, m_match;
  bit [15:0] m_pre, m_phase;
  bit [31:0] m_cnt, m_cmp;

  function automatic bit f_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) <= 32'd16) && ((a % 4) == 0);
  endfunction

  function automatic logic [31:0] f_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (f_hit(a)) begin
      case (a - BASE)
        32'd0:   v = {29'd0, m_ie, m_ar, m_en};
        32'd4:   v = {16'd0, m_pre};
        32'd8:   v = m_cnt;
        32'd12:  v = m_cmp;
        32'd16:  v = {31'd0, m_match};
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic model_step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit          tick, eq, wr;
    logic [31:0] off;
    if (r) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
      m_pre = 0; m_phase = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
    end else begin
      tick = m_en && (m_phase == m_pre);
      eq   = (m_cnt == m_cmp);
      wr   = we && f_hit(a);
      off  = a - BASE;
      if (m_en) m_phase = tick ? 16'd0 : m_phase + 16'd1;
      if (tick) m_cnt = (eq && m_ar) ? 32'd0 : m_cnt + 32'd1;
      if (wr && off == 32'd16 && d[0]) m_match = 0;
      if (tick && eq) m_match = 1;
      if (wr) begin
        case (off)
          32'd0:  begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
          32'd4:  begin m_pre = d[15:0]; m_phase = 16'd0; end
          32'd8:  m_cnt = d;
          32'd12: m_cmp = d;
          default: ;
        endcase
      end
    end
  endtask

  // One bus cycle: drive, queue the expected response for this cycle, advance the model.
  task automatic cycle(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    reset = r; memwrite = we; memaddr = a; memwritedata = d;
    e.hit = f_hit(a);
    e.rd  = f_read(a);
    e.irq = m_match & m_ie;
    e.cyc = ncyc;
    exp_q.push_back(e);
    ncyc++;
    model_step(r, we, a, d);
  endtask

  task automatic wr32(input logic [31:0] off, input logic [31:0] d);
    cycle(1'b0, 1'b1, BASE + off, d);
  endtask

  task automatic rd32(input logic [31:0] off);
    cycle(1'b0, 1'b0, BASE + off, 32'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, BASE, 32'd0);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (hit !== e.hit) begin
          errors++;
          $display("FAIL hit cyc=%0d addr=%h got=%b exp=%b", e.cyc, memaddr, hit, e.hit);
        end
        checks++;
        if (readdata !== e.rd) begin
          errors++;
          $display("FAIL readdata cyc=%0d addr=%h got=%h exp=%h", e.cyc, memaddr, readdata, e.rd);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, irq, e.irq);
        end
      end
    end
  end

  initial begin
    logic [31:0] offs [11];
    logic [31:0] off, d;
    int          k;
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
             32'h01, 32'h06, 32'h0B};

    reset = 1'b1; memwrite = 1'b0; memaddr = 32'd0; memwritedata = 32'd0;
    model_step(1'b1, 1'b0, 32'd0, 32'd0);

    // Reset state
    rd32(32'h0C); rd32(32'h00); rd32(32'h08); rd32(32'h10); rd32(32'h04);

    // PRESCALE=0, COMPARE=3, EN|IRQ_EN
    wr32(32'h04, 32'd0); wr32(32'h0C, 32'd3); wr32(32'h00, 32'h5);
    repeat (6) rd32(32'h08);
    rd32(32'h10);
    wr32(32'h10, 32'd1); rd32(32'h10);

    // PRESCALE=2, EN|AUTORELOAD, COMPARE=1
    do_reset();
    wr32(32'h04, 32'd2); wr32(32'h0C, 32'd1); wr32(32'h00, 32'h3);
    repeat (14) rd32(32'h08);
    rd32(32'h10);

    // Wrap through 0xFFFF_FFFF without a match
    do_reset();
    wr32(32'h08, 32'hFFFF_FFFE); wr32(32'h0C, 32'd5); wr32(32'h04, 32'd0); wr32(32'h00, 32'h1);
    repeat (3) rd32(32'h08);
    rd32(32'h10);

    // COUNT write in a tick cycle wins over the increment
    do_reset();
    wr32(32'h04, 32'd0); wr32(32'h00, 32'h1); rd32(32'h08);
    wr32(32'h08, 32'h100); rd32(32'h08); rd32(32'h08);

    // W1C colliding with a new match
    do_reset();
    wr32(32'h04, 32'd0); wr32(32'h0C, 32'd2); wr32(32'h00, 32'h5);
    rd32(32'h08); rd32(32'h08);
    wr32(32'h10, 32'd1);
    rd32(32'h10); rd32(32'h10);

    // Unmapped/misaligned accesses, then reset in the middle of counting
    wr32(32'h00, 32'h0);
    wr32(32'h14, 32'hFFFF_FFFF); wr32(32'h05, 32'h7); wr32(32'h09, 32'h55); rd32(32'h14); rd32(32'h05);
    cycle(1'b0, 1'b1, 32'h0000_0008, 32'h1234);
    rd32(32'h00); rd32(32'h04); rd32(32'h08); rd32(32'h0C); rd32(32'h10);
    wr32(32'h04, 32'd1); wr32(32'h00, 32'h7);
    repeat (5) rd32(32'h08);
    do_reset();
    rd32(32'h00); rd32(32'h04); rd32(32'h08); rd32(32'h0C); rd32(32'h10);
    wr32(32'h00, 32'h1); repeat (2) rd32(32'h08);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k   = $urandom_range(0, 10);
      off = offs[k];
      case (off)
        32'h04:  d = $urandom_range(0, 3);
        32'h08, 32'h0C: d = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 8);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 299) == 0)
        do_reset();
      else if ($urandom_range(0, 99) == 0)
        cycle(1'b0, 1'b1, $urandom, d);
      else
        cycle(1'b0, ($urandom_range(0, 3) == 0), BASE + off, d);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
